// File: rtl/ch_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ch_arbiter_pkg
// Brief    : Shared sizing constants and helpers for the CH round-robin arbiter
// Revision : 1.0 - initial release
// ============================================================================
package ch_arbiter_pkg;

  localparam int CH_ARB_DATA_W = 32;
  localparam int CH_ARB_N_REQ  = 4;
  localparam int CH_ARB_IDX_W  = $clog2(CH_ARB_N_REQ);
  localparam int CH_ARB_CNT_W  = 16;

  // Round-robin successor; N_REQ need not be a power of two.
  function automatic int ch_arb_rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ch_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ch_arbiter_if
// Brief    : Requester, CH-unit and response bundle of the CH arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface ch_arbiter_if
  import ch_arbiter_pkg::*;
#(
  parameter int DATA_W = CH_ARB_DATA_W,
  parameter int N_REQ  = CH_ARB_N_REQ,
  parameter int IDX_W  = CH_ARB_IDX_W
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_in0;
  logic [N_REQ*DATA_W-1:0] req_in1;
  logic [N_REQ*DATA_W-1:0] req_in2;
  logic [N_REQ-1:0]        gnt;
  logic [DATA_W-1:0]       ch_in0;
  logic [DATA_W-1:0]       ch_in1;
  logic [DATA_W-1:0]       ch_in2;
  logic [DATA_W-1:0]       ch_out0;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDX_W-1:0]        rsp_id;
  logic [DATA_W-1:0]       rsp_data;

  // Arbiter side
  modport slave (
    input  req, req_in0, req_in1, req_in2, ch_out0, rsp_ready,
    output gnt, ch_in0, ch_in1, ch_in2, rsp_valid, rsp_id, rsp_data
  );

  // Requesters, CH unit and consumer side
  modport master (
    output req, req_in0, req_in1, req_in2, ch_out0, rsp_ready,
    input  gnt, ch_in0, ch_in1, ch_in2, rsp_valid, rsp_id, rsp_data
  );

endinterface
`default_nettype wire

// File: rtl/ch_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : ch_rr_pick
// Brief    : Combinational round-robin picker, searching upward from rr_ptr
// Revision : 1.0 - initial release
// ============================================================================
module ch_rr_pick
  import ch_arbiter_pkg::*;
#(
  parameter int N_REQ = CH_ARB_N_REQ,
  parameter int IDX_W = CH_ARB_IDX_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  function automatic logic [IDX_W-1:0] cand(input logic [IDX_W-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  // Scan farthest-first so the nearest requester is the last write and wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[cand(rr_ptr, k)]) begin
        any = 1'b1;
        idx = cand(rr_ptr, k);
      end
    end
    gnt[idx] = any;
  end

endmodule
`default_nettype wire

// File: rtl/ch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ch_arbiter
// Brief    : Round-robin sharing of one CH unit, two-stage pipeline with
//            response backpressure. CH_ARB_STATS_EN adds grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module ch_arbiter
  import ch_arbiter_pkg::*;
#(
  parameter int DATA_W = CH_ARB_DATA_W,
  parameter int N_REQ  = CH_ARB_N_REQ,
  parameter int IDX_W  = CH_ARB_IDX_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic                          stat_clr,
  output logic [N_REQ*CH_ARB_CNT_W-1:0] stat_cnt,
  ch_arbiter_if.slave                   bus
);

  logic [N_REQ-1:0]  w_pick_gnt;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic              w_stall;
  logic              w_s1_accept;
  logic              w_issue;
  logic [DATA_W-1:0] w_op0;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;

  logic [IDX_W-1:0]  r_rr_ptr;
  logic              r_s1_valid;
  logic [IDX_W-1:0]  r_s1_id;
  logic [DATA_W-1:0] r_ch_in0;
  logic [DATA_W-1:0] r_ch_in1;
  logic [DATA_W-1:0] r_ch_in2;
  logic              r_rsp_valid;
  logic [IDX_W-1:0]  r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;

  ch_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (bus.req),
    .rr_ptr (r_rr_ptr),
    .gnt    (w_pick_gnt),
    .idx    (w_pick_idx),
    .any    (w_pick_any)
  );

  assign w_stall     = r_rsp_valid & ~bus.rsp_ready;
  assign w_s1_accept = ~w_stall | ~r_s1_valid;
  // rst gating keeps gnt low combinationally while reset is held.
  assign w_issue     = rst & run & w_pick_any & w_s1_accept;

  assign w_op0 = bus.req_in0[w_pick_idx*DATA_W +: DATA_W];
  assign w_op1 = bus.req_in1[w_pick_idx*DATA_W +: DATA_W];
  assign w_op2 = bus.req_in2[w_pick_idx*DATA_W +: DATA_W];

  assign bus.gnt       = w_issue ? w_pick_gnt : '0;
  assign bus.ch_in0    = r_ch_in0;
  assign bus.ch_in1    = r_ch_in1;
  assign bus.ch_in2    = r_ch_in2;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr    <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_id     <= '0;
      r_ch_in0    <= '0;
      r_ch_in1    <= '0;
      r_ch_in2    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (w_issue) begin
        r_s1_valid <= 1'b1;
        r_s1_id    <= w_pick_idx;
        r_ch_in0   <= w_op0;
        r_ch_in1   <= w_op1;
        r_ch_in2   <= w_op2;
        r_rr_ptr   <= IDX_W'(ch_arb_rr_next(int'(w_pick_idx), N_REQ));
      end else if (!w_stall) begin
        r_s1_valid <= 1'b0;
      end
      if (!w_stall) begin
        r_rsp_valid <= r_s1_valid;
        r_rsp_id    <= r_s1_id;
        r_rsp_data  <= bus.ch_out0;
      end
    end
  end

`ifdef CH_ARB_STATS_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    logic [CH_ARB_CNT_W-1:0] r_cnt;

    // Clear wins over a same-cycle grant; count saturates at all-ones.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt <= '0;
      end else if (stat_clr) begin
        r_cnt <= '0;
      end else if (bus.gnt[i] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign stat_cnt[i*CH_ARB_CNT_W +: CH_ARB_CNT_W] = r_cnt;
  end
`else
  logic w_unused_stat_clr;
  assign w_unused_stat_clr = stat_clr;
  assign stat_cnt          = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ch_arbiter
// Brief    : Scoreboard bench for ch_arbiter with an external CH model
// Revision : 1.0 - initial release
// ============================================================================
module tb_ch_arbiter;
  import ch_arbiter_pkg::*;

  localparam int DATA_W = 32;
  localparam int N_REQ  = 4;
  localparam int IDX_W  = 2;

  typedef struct {
    logic [IDX_W-1:0]  id;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic run;
  logic stat_clr;
  logic [N_REQ*CH_ARB_CNT_W-1:0] stat_cnt;

  ch_arbiter_if #(.DATA_W(DATA_W), .N_REQ(N_REQ), .IDX_W(IDX_W)) bus ();

  ch_arbiter #(
    .DATA_W (DATA_W),
    .N_REQ  (N_REQ),
    .IDX_W  (IDX_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] ch_fn(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [DATA_W-1:0] c);
    return (a & b) | (~a & c);
  endfunction

  // External CH unit
  assign bus.ch_out0 = ch_fn(bus.ch_in0, bus.ch_in1, bus.ch_in2);

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  exp_t              sb[$];
  exp_t              mon_e;
  bit                m_s1, m_s2;
  int                m_ptr;
  logic [15:0]       m_cnt[N_REQ];
  bit                mon_stall, mon_accept, mon_any, mon_issue;
  int                mon_idx, mon_c;
  logic [N_REQ-1:0]  mon_gnt;
  logic [N_REQ*CH_ARB_CNT_W-1:0] mon_stat;

  always @(negedge clk) begin
    if (!rst) begin
      check_eq("gnt_in_rst", 64'(bus.gnt), 64'd0);
      check_eq("valid_in_rst", 64'(bus.rsp_valid), 64'd0);
      m_s1  = 1'b0;
      m_s2  = 1'b0;
      m_ptr = 0;
      for (int i = 0; i < N_REQ; i++) m_cnt[i] = '0;
      sb.delete();
    end else begin
      mon_stall  = m_s2 && !bus.rsp_ready;
      mon_accept = !mon_stall || !m_s1;
      mon_any    = 1'b0;
      mon_idx    = 0;
      for (int k = 0; k < N_REQ; k++) begin
        mon_c = (m_ptr + k) % N_REQ;
        if (!mon_any && bus.req[mon_c]) begin
          mon_any = 1'b1;
          mon_idx = mon_c;
        end
      end
      mon_issue = run && mon_any && mon_accept;
      mon_gnt   = '0;
      if (mon_issue) mon_gnt[mon_idx] = 1'b1;

      check_eq("gnt", 64'(bus.gnt), 64'(mon_gnt));
      check_eq("rsp_valid", 64'(bus.rsp_valid), 64'(m_s2));
      if (m_s2) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          check_eq("rsp_id", 64'(bus.rsp_id), 64'(sb[0].id));
          check_eq("rsp_data", 64'(bus.rsp_data), 64'(sb[0].data));
          if (bus.rsp_ready) mon_e = sb.pop_front();
        end
      end

      if (mon_issue) begin
        mon_e.id   = mon_idx[IDX_W-1:0];
        mon_e.data = ch_fn(bus.req_in0[mon_idx*DATA_W +: DATA_W],
                           bus.req_in1[mon_idx*DATA_W +: DATA_W],
                           bus.req_in2[mon_idx*DATA_W +: DATA_W]);
        sb.push_back(mon_e);
      end

      if (!mon_stall) m_s2 = m_s1;
      if (mon_issue) m_s1 = 1'b1;
      else if (!mon_stall) m_s1 = 1'b0;
      if (mon_issue) m_ptr = (mon_idx + 1) % N_REQ;

`ifdef CH_ARB_STATS_EN
      for (int i = 0; i < N_REQ; i++) mon_stat[i*CH_ARB_CNT_W +: CH_ARB_CNT_W] = m_cnt[i];
      check_eq("stat_cnt", 64'(stat_cnt), 64'(mon_stat));
      for (int i = 0; i < N_REQ; i++) begin
        if (stat_clr) m_cnt[i] = '0;
        else if (mon_gnt[i] && m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
      end
`else
      mon_stat = '0;
      check_eq("stat_zero", 64'(stat_cnt), 64'(mon_stat));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c);
    bus.req_in0[i*DATA_W +: DATA_W] = a;
    bus.req_in1[i*DATA_W +: DATA_W] = b;
    bus.req_in2[i*DATA_W +: DATA_W] = c;
  endtask

  int wait_cnt;

  initial begin
    rst           = 1'b0;
    run           = 1'b0;
    stat_clr      = 1'b0;
    bus.req       = '0;
    bus.req_in0   = '0;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    bus.rsp_ready = 1'b1;
    #3;
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    check_eq("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    check_eq("rst_ch_in", 64'({bus.ch_in0, bus.ch_in1} | 64'(bus.ch_in2)), 64'd0);
    check_eq("rst_stat", 64'(stat_cnt), 64'd0);
    step(2);
    rst = 1'b1;

    // Single operation with a known CH result
    set_ops(0, 32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0);
    bus.req = 4'b0001;
    run     = 1'b1;
    #1;
    check_eq("single_gnt", 64'(bus.gnt), 64'h1);
    step(1);
    bus.req = '0;
    step(1);
    check_eq("single_valid", 64'(bus.rsp_valid), 64'd1);
    check_eq("single_id", 64'(bus.rsp_id), 64'd0);
    check_eq("single_data", 64'(bus.rsp_data), 64'h1234DEF0);
    step(2);

    // All requesting, selector zero so every result is the if-0 operand
    for (int i = 0; i < N_REQ; i++) set_ops(i, 32'h0, 32'h11111111 * (i + 1), 32'hDEADBEEF);
    bus.req = 4'b1111;
    step(4);
    check_eq("deadbeef", 64'(bus.rsp_data), 64'hDEADBEEF);
    step(8);
    bus.req = '0;
    step(3);

    // Distinct random operands
    for (int i = 0; i < N_REQ; i++) set_ops(i, $urandom, $urandom, $urandom);
    bus.req = 4'b1111;
    step(12);

    // Backpressure for 5 cycles
    bus.rsp_ready = 1'b0;
    step(5);
    check_eq("bp_full_gnt", 64'(bus.gnt), 64'd0);
    bus.rsp_ready = 1'b1;
    step(8);

    // run drops with operations in flight
    run = 1'b0;
    step(4);
    check_eq("run0_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("run0_gnt", 64'(bus.gnt), 64'd0);
    run = 1'b1;
    step(6);

    // Async reset between clock edges
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("arst_gnt", 64'(bus.gnt), 64'd0);
    check_eq("arst_data", 64'(bus.rsp_data), 64'd0);
    step(2);
    rst = 1'b1;
    #1;
    check_eq("post_rst_gnt", 64'(bus.gnt), 64'h1);
    step(6);

`ifdef CH_ARB_STATS_EN
    bus.req = '0;
    step(3);
    bus.req  = 4'b0100;
    stat_clr = 1'b1;
    step(1);
    stat_clr = 1'b0;
    check_eq("stat_clr_win", 64'(stat_cnt[2*CH_ARB_CNT_W +: CH_ARB_CNT_W]), 64'd0);
    step(10);
    bus.req = '0;
    check_eq("stat_ten", 64'(stat_cnt[2*CH_ARB_CNT_W +: CH_ARB_CNT_W]), 64'd10);
    step(3);
    bus.req = 4'b0100;
    step(65540);
    bus.req = '0;
    step(1);
    check_eq("stat_sat", 64'(stat_cnt[2*CH_ARB_CNT_W +: CH_ARB_CNT_W]), 64'hFFFF);
`else
    stat_clr = 1'b1;
    step(3);
    stat_clr = 1'b0;
    check_eq("stat_off", 64'(stat_cnt), 64'd0);
`endif

    // Drain and confirm nothing outstanding
    bus.req  = '0;
    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 20) begin
      step(1);
      wait_cnt++;
    end
    check_eq("drain", 64'(sb.size()), 64'd0);
    step(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
